array_gate_seq: RTL

ARRAY_GATE_SEQ -- requirements
Module: array_gate_seq

---
 rtl/array_gate_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/array_gate_seq.sv
// Break-before-make sequencer for an array of PMOS fingers (active-low gate drive).
// Optional completed-update counter cnt_done when ARRAY_GATE_SEQ_CNT_EN is defined.
module array_gate_seq #(
  parameter int NFING    = 2,
  parameter int DEAD_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             force_off,
  input  logic             req_valid,
  input  logic [NFING-1:0] req_code,
  output logic             req_ready,
  output logic [NFING-1:0] gate,
  output logic             done
`ifdef ARRAY_GATE_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_done
`endif
);

  typedef enum logic [1:0] {IDLE, BREAK, DEAD, MAKE} state_t;

  localparam logic [7:0] DEAD_LD = 8'(DEAD_CYC);

  if (NFING < 1 || NFING > 16 || DEAD_CYC < 0 || DEAD_CYC > 255 || CNT_W < 1) begin : g_bad_param
    $error("array_gate_seq: parameter out of range");
  end

  state_t           state;
  state_t           state_nx;
  logic [7:0]       dead_cnt;
  logic [NFING-1:0] nxt;
  logic             rdy_q;
  logic             hs;
  logic [NFING-1:0] gate_d;
  logic             done_d;

  // rdy_q holds ready low for the done cycle and for the first cycle out of reset
  assign req_ready = rdy_q && (state == IDLE) && !force_off;
  assign hs        = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dead_cnt <= '0;
      nxt      <= '0;
      rdy_q    <= 1'b0;
      gate     <= '1;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      gate  <= gate_d;
      done  <= done_d;
      rdy_q <= (state == IDLE);
      if (hs) begin
        nxt <= req_code;
      end
      if (force_off) begin
        dead_cnt <= '0;
      end else if (state == BREAK) begin
        dead_cnt <= DEAD_LD;
      end else if (state == DEAD && dead_cnt != 8'd0) begin
        dead_cnt <= dead_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (hs) state_nx = BREAK;
      BREAK: state_nx = (DEAD_CYC > 0) ? DEAD : MAKE;
      DEAD:  if (dead_cnt <= 8'd1) state_nx = MAKE;
      MAKE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (force_off) begin
      state_nx = IDLE;
    end
  end

  // Gate only ever drops fingers on the handshake and only adds them leaving MAKE
  always_comb begin
    gate_d = gate;
    done_d = 1'b0;
    if (force_off) begin
      gate_d = '1;
    end else begin
      case (state)
        IDLE: if (hs) gate_d = ~(~gate & req_code);
        MAKE: begin
          gate_d = ~nxt;
          done_d = 1'b1;
        end
        default: gate_d = gate;
      endcase
    end
  end

`ifdef ARRAY_GATE_SEQ_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_done <= '0;
    end else if (done_d && (cnt_done != {CNT_W{1'b1}})) begin
      cnt_done <= cnt_done + CNT_W'(1);
    end
  end
`endif

endmodule
